// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter: N_CH EU result channels plus one max-priority channel,
// round-robin or fixed priority, with a registered output stage towards the ROB.
module cdb_rr_arbiter #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int RR_EN  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    input  logic                      max_prio_valid_i,
    input  logic [DATA_W-1:0]         max_prio_data_i,
    output logic                      max_prio_ready_o,
    input  logic [N_CH-1:0]           valid_i,
    input  logic [N_CH*DATA_W-1:0]    data_i,
    output logic [N_CH-1:0]           ready_o,
    output logic                      rob_valid_o,
    input  logic                      rob_ready_i,
    output logic [DATA_W-1:0]         rob_data_o,
    output logic                      served_max_prio_o,
    output logic [$clog2(N_CH)-1:0]   served_o
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  scan_start;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              free;
    logic              grant_en;
    logic              max_grant;
    logic              eu_grant;
    logic [DATA_W-1:0] win_data;

    // Pointer advance with explicit wrap so non-power-of-two N_CH works.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_CH - 1))
            next_idx = '0;
        else
            next_idx = idx + 1'b1;
    endfunction

    // Cyclic first-set search starting at 'start'; returns {found, index}.
    function automatic logic [IDX_W:0] scan(input logic [N_CH-1:0]  req,
                                            input logic [IDX_W-1:0] start);
        logic [IDX_W:0]   cand;
        logic             found;
        logic [IDX_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_CH))
                cand = cand - (IDX_W+1)'(N_CH);
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = cand[IDX_W-1:0];
            end
        end
        return {found, win};
    endfunction

    assign free       = ~rob_valid_o | rob_ready_i;
    assign scan_start = (RR_EN != 0) ? rr_ptr : '0;

    always_comb begin
        grant_en             = rst_n_i & free & ~flush_i;
        {win_found, win_idx} = scan(valid_i, scan_start);
        max_grant            = grant_en & max_prio_valid_i;
        eu_grant             = grant_en & ~max_prio_valid_i & win_found;
        ready_o              = '0;
        if (eu_grant)
            ready_o[win_idx] = 1'b1;
        max_prio_ready_o     = max_grant;
        win_data             = data_i[win_idx*DATA_W +: DATA_W];
    end

    // Output register stage: breaks the EU-to-ROB path; reloads while draining.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rob_valid_o       <= 1'b0;
            rob_data_o        <= '0;
            served_o          <= '0;
            served_max_prio_o <= 1'b0;
            rr_ptr            <= '0;
        end else if (flush_i) begin
            rob_valid_o <= 1'b0;
            rr_ptr      <= '0;
        end else if (free) begin
            if (max_grant) begin
                rob_valid_o       <= 1'b1;
                rob_data_o        <= max_prio_data_i;
                served_o          <= '0;
                served_max_prio_o <= 1'b1;
            end else if (eu_grant) begin
                rob_valid_o       <= 1'b1;
                rob_data_o        <= win_data;
                served_o          <= win_idx;
                served_max_prio_o <= 1'b0;
                if (RR_EN != 0)
                    rr_ptr <= next_idx(win_idx);
            end else begin
                rob_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter: a round-robin instance and a fixed-priority
// instance sharing the EU request inputs.
module tb_cdb_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            mp_valid;
    logic [DW-1:0]   mp_data;
    logic            mp_ready;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            rob_valid;
    logic            rob_ready;
    logic [DW-1:0]   rob_data;
    logic            served_mp;
    logic [1:0]      served;

    logic            f_mp_ready;
    logic [N-1:0]    f_ready;
    logic            f_rob_valid;
    logic [DW-1:0]   f_rob_data;
    logic            f_served_mp;
    logic [1:0]      f_served;
    logic            f_zero;
    logic            f_one;
    logic [DW-1:0]   f_mp_data;

    int checks = 0;
    int errors = 0;

    cdb_rr_arbiter #(.N_CH(N), .DATA_W(DW), .RR_EN(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .max_prio_valid_i(mp_valid), .max_prio_data_i(mp_data), .max_prio_ready_o(mp_ready),
        .valid_i(valid), .data_i(data), .ready_o(ready),
        .rob_valid_o(rob_valid), .rob_ready_i(rob_ready), .rob_data_o(rob_data),
        .served_max_prio_o(served_mp), .served_o(served)
    );

    cdb_rr_arbiter #(.N_CH(N), .DATA_W(DW), .RR_EN(0)) dut_fixed (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(f_zero),
        .max_prio_valid_i(f_zero), .max_prio_data_i(f_mp_data), .max_prio_ready_o(f_mp_ready),
        .valid_i(valid), .data_i(data), .ready_o(f_ready),
        .rob_valid_o(f_rob_valid), .rob_ready_i(f_one), .rob_data_o(f_rob_data),
        .served_max_prio_o(f_served_mp), .served_o(f_served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pay(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        valid     = 4'b1111;
        mp_valid  = 1'b1;
        rob_ready = 1'b1;
        tick();
        tick();
        checks++; if (rob_valid !== 1'b0) begin errors++; $display("FAIL reset_rob_valid act=%b exp=0", rob_valid); end
        checks++; if (rob_data !== 64'h0) begin errors++; $display("FAIL reset_rob_data act=%h exp=0", rob_data); end
        checks++; if (served !== 2'd0 || served_mp !== 1'b0) begin errors++; $display("FAIL reset_served act=%0d/%b exp=0/0", served, served_mp); end
        checks++; if (ready !== 4'b0000 || mp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready act=%b/%b exp=0000/0", ready, mp_ready); end
        checks++; if (f_rob_valid !== 1'b0 || f_ready !== 4'b0000) begin errors++; $display("FAIL reset_fixed act=%b/%b exp=0/0000", f_rob_valid, f_ready); end
        mp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL release_ready act=%b exp=0001", ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rob_valid !== 1'b1 || served !== 2'(i % 4) || rob_data !== pay(i % 4)) begin
                errors++; $display("FAIL rr_seq[%0d] act=%b/%0d/%h exp=1/%0d/%h", i, rob_valid, served, rob_data, i % 4, pay(i % 4));
            end
            checks++; if (ready !== 4'(1 << ((i + 1) % 4))) begin errors++; $display("FAIL rr_seq_ready[%0d] act=%b exp=%b", i, ready, 4'(1 << ((i + 1) % 4))); end
        end
        // pointer now 1
    endtask

    task automatic test_rr_wrap();
        valid = 4'b0100;
        #1;
        checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL wrap_pre_ready act=%b exp=0100", ready); end
        tick();
        valid = 4'b0011;
        #1;
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready act=%b exp=0001", ready); end
        checks++; if (f_ready !== 4'b0001) begin errors++; $display("FAIL fixed_ready0 act=%b exp=0001", f_ready); end
        tick();
        checks++; if (served !== 2'd0 || rob_data !== pay(0)) begin errors++; $display("FAIL wrap_served act=%0d/%h exp=0/%h", served, rob_data, pay(0)); end
        checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1 act=%b exp=0010", ready); end
        checks++; if (f_ready !== 4'b0001 || f_served !== 2'd0) begin errors++; $display("FAIL fixed_ready1 act=%b/%0d exp=0001/0", f_ready, f_served); end
        tick();
        checks++; if (served !== 2'd1) begin errors++; $display("FAIL wrap_served1 act=%0d exp=1", served); end
        valid = 4'b0000;
        tick();
        checks++; if (rob_valid !== 1'b0) begin errors++; $display("FAIL idle_drain act=%b exp=0", rob_valid); end
        // pointer now 2
    endtask

    task automatic test_back_pressure();
        data[2*DW +: DW] = 64'hA5;
        valid = 4'b0100;
        tick();
        checks++; if (rob_valid !== 1'b1 || rob_data !== 64'hA5) begin errors++; $display("FAIL bp_load act=%b/%h exp=1/a5", rob_valid, rob_data); end
        rob_ready = 1'b0;
        data[2*DW +: DW] = 64'h5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] act=%b exp=0000", i, ready); end
            tick();
            checks++; if (rob_valid !== 1'b1 || rob_data !== 64'hA5 || served !== 2'd2 || served_mp !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] act=%b/%h/%0d/%b exp=1/a5/2/0", i, rob_valid, rob_data, served, served_mp);
            end
        end
        rob_ready = 1'b1;
        #1;
        checks++; if (ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready act=%b exp=0100", ready); end
        tick();
        checks++; if (rob_valid !== 1'b1 || rob_data !== 64'h5A || served !== 2'd2) begin errors++; $display("FAIL bp_reload act=%b/%h/%0d exp=1/5a/2", rob_valid, rob_data, served); end
        valid = 4'b0000;
        data[2*DW +: DW] = pay(2);
        tick();
        // pointer now 3
    endtask

    task automatic test_max_prio();
        valid    = 4'b1111;
        mp_valid = 1'b1;
        mp_data  = 64'hBEEF;
        #1;
        checks++; if (mp_ready !== 1'b1 || ready !== 4'b0000) begin errors++; $display("FAIL mp_grant act=%b/%b exp=1/0000", mp_ready, ready); end
        tick();
        checks++; if (served_mp !== 1'b1 || served !== 2'd0 || rob_data !== 64'hBEEF || rob_valid !== 1'b1) begin
            errors++; $display("FAIL mp_capture act=%b/%0d/%h/%b exp=1/0/beef/1", served_mp, served, rob_data, rob_valid);
        end
        mp_valid = 1'b0;
        #1;
        checks++; if (ready !== 4'b1000 || mp_ready !== 1'b0) begin errors++; $display("FAIL mp_ptr_kept act=%b/%b exp=1000/0", ready, mp_ready); end
        tick();
        checks++; if (served !== 2'd3 || served_mp !== 1'b0 || rob_data !== pay(3)) begin errors++; $display("FAIL mp_after act=%0d/%b/%h exp=3/0/%h", served, served_mp, rob_data, pay(3)); end
        valid = 4'b0000;
        tick();
        // pointer now 0
    endtask

    task automatic test_flush();
        valid = 4'b0001;
        tick();
        checks++; if (rob_valid !== 1'b1 || served !== 2'd0) begin errors++; $display("FAIL flush_prefill act=%b/%0d exp=1/0", rob_valid, served); end
        flush    = 1'b1;
        valid    = 4'b0010;
        mp_valid = 1'b1;
        #1;
        checks++; if (ready !== 4'b0000 || mp_ready !== 1'b0) begin errors++; $display("FAIL flush_no_grant act=%b/%b exp=0000/0", ready, mp_ready); end
        tick();
        checks++; if (rob_valid !== 1'b0) begin errors++; $display("FAIL flush_clear act=%b exp=0", rob_valid); end
        flush    = 1'b0;
        mp_valid = 1'b0;
        #1;
        checks++; if (ready !== 4'b0010) begin errors++; $display("FAIL flush_eu1_ready act=%b exp=0010", ready); end
        tick();
        checks++; if (rob_valid !== 1'b1 || served !== 2'd1 || rob_data !== pay(1)) begin errors++; $display("FAIL flush_eu1_served act=%b/%0d/%h exp=1/1/%h", rob_valid, served, rob_data, pay(1)); end
        valid = 4'b0000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        valid = 4'b0101;
        #1;
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL flush_ptr_zero act=%b exp=0001", ready); end
        tick();
        valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        valid = 4'b0100;
        tick();
        rob_ready = 1'b0;
        valid     = 4'b0000;
        #2;
        checks++; if (rob_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill act=%b exp=1", rob_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (rob_valid !== 1'b0 || rob_data !== 64'h0 || served !== 2'd0) begin
            errors++; $display("FAIL mid_async act=%b/%h/%0d exp=0/0/0", rob_valid, rob_data, served);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rob_ready = 1'b1;
        valid     = 4'b1111;
        #1;
        checks++; if (ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero act=%b exp=0001", ready); end
        valid = 4'b0000;
    endtask

    initial begin
        flush     = 1'b0;
        mp_valid  = 1'b0;
        mp_data   = '0;
        rob_ready = 1'b1;
        valid     = '0;
        f_zero    = 1'b0;
        f_one     = 1'b1;
        f_mp_data = '0;
        for (int k = 0; k < N; k++) data[k*DW +: DW] = pay(k);
        test_reset();
        test_rr_wrap();
        test_back_pressure();
        test_max_prio();
        test_flush();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
